// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// states, opcodes, funct codes, ALU controls and mux selects.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_terminal(input state_e s);
        return (s == S_MEMWB) || (s == S_MEMWR) ||
               (s == S_ALUWB) || (s == S_ADDIWB) ||
               (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode: alu_op selects add, sub or a funct-driven
// operation for R-type instructions.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD: alu_ctrl_o = ALU_ADD;
            ALUOP_SUB: alu_ctrl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alu_ctrl_o = ALU_ADD;
                    FN_SUB:  alu_ctrl_o = ALU_SUB;
                    FN_AND:  alu_ctrl_o = ALU_AND;
                    FN_OR:   alu_ctrl_o = ALU_OR;
                    FN_SLT:  alu_ctrl_o = ALU_SLT;
                    default: alu_ctrl_o = ALU_ADD;
                endcase
            end
            default: alu_ctrl_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing a multi-cycle MIPS datapath, with a
// retired-instruction counter.
module multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pc_write;
    logic       branch;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Count only on the exit from a state that completes an instruction.
    always_comb begin
        cnt_d = cnt_q;
        if (is_terminal(state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        i_or_d      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_B;
        pc_src      = PCSRC_ALU;
        alu_op      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = SRCB_4;
                pc_write   = 1'b1;
            end
            S_DECODE: alu_src_b = SRCB_IMM2;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: i_or_d = 1'b1;
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_s = 1'b1;
            end
            S_MEMWR: begin
                i_or_d      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDIWB: reg_write_s = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op_i   (alu_op),
        .funct_i    (funct),
        .alu_ctrl_o (alu_ctrl)
    );

    // Strobes are held off for the whole time reset is high.
    assign pc_en       = ~reset & (pc_write | (branch & zero));
    assign ir_write    = ~reset & ir_write_s;
    assign reg_write   = ~reset & reg_write_s;
    assign mem_write   = ~reset & mem_write_s;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule
